fwd_operand_sel: RTL and testbench
==================================

Name: fwd_operand_sel

Overview:
- Parametrised ID-stage operand selector with forwarding for the 5-stage pipeline.
- Generalises the fixed 2/3/5-input 32-bit selectors: data width, register-address width and pipeline tag tracking are parameters.
- Keeps its own EX/MEM/WB destination-tag pipeline and drives four-way forwarding for both source operands.
- Detects load-use hazards, issues a stall and inserts a bubble; keeps a saturating stall counter for performance checks.

Parameters:
- DW, 32, data width of operands and results.
- AW, 5, register address width; address 0 is hard-wired zero.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  source register addresses.
- id_rs_used, id_rt_used  in  1  the operand is actually read.
- id_rd  in  AW  destination address of the ID instruction.
- id_wen  in  1  the ID instruction writes a register.
- id_load  in  1  the ID instruction is a load.
- rf_rs_data, rf_rt_data  in  DW  register-file read data.
- ex_result  in  DW  ALU result in EX.
- mem_result  in  DW  MEM-stage result; load data for loads.
- wb_result  in  DW  write-back data.
- flush  in  1  squash the ID instruction (taken branch or jump).
- ext_hold  in  1  freeze the whole pipeline (memory wait).
- op_a, op_b  out  DW  selected operands (combinational).
- sel_a, sel_b  out  2  00 = RF, 01 = EX, 10 = MEM, 11 = WB.
- stall  out  1  load-use stall request to the PC and IF/ID.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Reset is asynchronous and active-low, on rst_n.
- State is three tag slots, EX, MEM and WB. Each slot holds {v, rd, wen, load}.
- Reset: all v = 0, stall_cnt = 0.
- Reset outputs: stall = 0, sel_a = sel_b = 00, op_a = rf_rs_data, op_b = rf_rt_data.
- A slot "matches" address r when v && wen && rd == r && r != 0.
- Operand select, evaluated separately for rs → a and rt → b, in priority order:
  - EX matches and EX.load = 0 → 01.
  - else MEM matches → 10.
  - else WB matches → 11.
  - else → 00.
- An operand with *_used = 0 or address 0 always selects 00.
- stall = id_valid && !flush && EX.v && EX.load && EX.wen && EX.rd != 0, and also (rs used and matching EX.rd, or rt used and matching EX.rd).
- During a stall, sel/op still show the lower-priority source; downstream ignores them because a bubble is injected.
- Tag update on each rising clk, when ext_hold = 0:
  - WB ← MEM; MEM ← EX.
  - EX ← bubble (v = 0) if stall or flush or !id_valid.
  - Otherwise EX ← {1, id_rd, id_wen, id_load}.
- ext_hold = 1: all slots hold, stall_cnt holds, and outputs stay combinational on the held tags.
- Simultaneous events:
  - flush together with stall: flush wins, stall = 0, bubble enters EX.
  - ext_hold wins over stall and flush for state update; stall output is still driven.
- stall_cnt increments by 1 on each clock with stall = 1 and ext_hold = 0, and saturates at 2^CNT_W − 1.
- Latency:
  - Selection is zero-cycle combinational.
  - A load-use hazard costs exactly one stall cycle.
  - On the next cycle the load sits in MEM and is forwarded with sel = 10.
- Reset mid-operation: all tags are invalidated immediately; in-flight producers are never forwarded afterwards.
- op width equals DW on every path; no truncation or extension.

Decomposition:
- Shared package: select-code constants FWD_RF, FWD_EX, FWD_MEM, FWD_WB; a tag-record typedef {v, rd, wen, load}; the DW/AW defaults.
- One natural sub-module, fwd_match_sel. It is instantiated twice (a and b) and maps an address plus the three tags to a select code and a DW-wide 4:1 mux.

Test Plan:
- Reset, then id_rs = 3 with no producers in flight → sel_a = 00, op_a = rf_rs_data, stall = 0, stall_cnt = 0.
- Producers in flight:
  - ALU add writing r5 sits in EX (ex_result = 0x11) and in MEM (0x22); ID reads rs = 5 → sel_a = 01, op_a = 0x11.
  - Same, but with EX invalid → 10, 0x22.
  - Only WB writes r5 (0x33) → 11, 0x33.
- Load to r7 in EX; ID uses rt = 7:
  - stall = 1 for exactly one cycle and stall_cnt = 1.
  - The next cycle has EX a bubble and sel_b = 10 with op_b = mem_result = 0xDEAD.
- Load to r7 in EX with flush = 1 in the same cycle → stall = 0, and EX.v = 0 after the clock.
- In-flight writer with rd = 0 (ex_result = 0xFF) and ID rs = 0 → sel_a = 00, op_a = rf data, no stall. Also: rs_used = 0 with a matching EX → sel_a = 00.
- Hold, reset and saturation:
  - ext_hold = 1 for 3 cycles during a load-use: tags and stall_cnt are unchanged and stall stays 1.
  - Release ext_hold → stall_cnt = 1.
  - With CNT_W = 2, forcing 5 stall cycles → stall_cnt = 3.
  - rst_n low mid-sequence → all tags cleared immediately, with no clock edge needed.

Source files
------------

// File: rtl/fwd_operand_sel_pkg.sv
`default_nettype none
// ============================================================================
// fwd_operand_sel_pkg : select codes, tag record and helpers for ID forwarding
// Revision : 1.0
// ============================================================================
package fwd_operand_sel_pkg;

  localparam int c_DW_DEF = 32;
  localparam int c_AW_DEF = 5;
  // Tag slots carry a fixed-width rd so the record type is shared by every AW.
  localparam int c_AW_MAX = 8;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic                v;
    logic [c_AW_MAX-1:0] rd;
    logic                wen;
    logic                load;
  } tag_t;

  localparam tag_t c_TAG_EMPTY = '0;

  // Register 0 is hard-wired zero, so it never matches a producer.
  function automatic logic tag_match(input tag_t t, input logic [c_AW_MAX-1:0] r);
    return t.v && t.wen && (t.rd == r) && (r != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_match_sel.sv
`default_nettype none
// ============================================================================
// fwd_match_sel : per-operand producer match, select code and DW-wide 4:1 mux
// Revision : 1.0
// ============================================================================
module fwd_match_sel
  import fwd_operand_sel_pkg::*;
#(
  parameter int DW = c_DW_DEF,
  parameter int AW = c_AW_DEF
) (
  input  logic          used,
  input  logic [AW-1:0] addr,
  input  tag_t          ex_tag,
  input  tag_t          mem_tag,
  input  tag_t          wb_tag,
  input  logic [DW-1:0] rf_data,
  input  logic [DW-1:0] ex_data,
  input  logic [DW-1:0] mem_data,
  input  logic [DW-1:0] wb_data,
  output logic [1:0]    sel,
  output logic [DW-1:0] data,
  output logic          ex_load_hit
);

  logic [c_AW_MAX-1:0] w_addr;
  logic                w_ex_hit;
  logic                w_mem_hit;
  logic                w_wb_hit;
  logic                w_unused_load;

  assign w_addr    = c_AW_MAX'(addr);
  assign w_ex_hit  = used && tag_match(ex_tag,  w_addr);
  assign w_mem_hit = used && tag_match(mem_tag, w_addr);
  assign w_wb_hit  = used && tag_match(wb_tag,  w_addr);

  // A load in EX has no data yet: it raises the hazard and falls through
  // to the older stages for the (ignored) operand value.
  assign ex_load_hit = w_ex_hit && ex_tag.load;

  assign w_unused_load = mem_tag.load ^ wb_tag.load;

  always_comb begin
    sel = FWD_RF;
    if (w_ex_hit && !ex_tag.load) begin
      sel = FWD_EX;
    end else if (w_mem_hit) begin
      sel = FWD_MEM;
    end else if (w_wb_hit) begin
      sel = FWD_WB;
    end
  end

  always_comb begin
    data = rf_data;
    case (sel)
      FWD_EX:  data = ex_data;
      FWD_MEM: data = mem_data;
      FWD_WB:  data = wb_data;
      default: data = rf_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fwd_operand_sel.sv
`default_nettype none
// ============================================================================
// fwd_operand_sel : ID-stage operand forwarding with load-use stall detection
// Revision : 1.0
// ============================================================================
module fwd_operand_sel
  import fwd_operand_sel_pkg::*;
#(
  parameter int DW    = c_DW_DEF,
  parameter int AW    = c_AW_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_wen,
  input  logic             id_load,
  input  logic [DW-1:0]    rf_rs_data,
  input  logic [DW-1:0]    rf_rt_data,
  input  logic [DW-1:0]    ex_result,
  input  logic [DW-1:0]    mem_result,
  input  logic [DW-1:0]    wb_result,
  input  logic             flush,
  input  logic             ext_hold,
  output logic [DW-1:0]    op_a,
  output logic [DW-1:0]    op_b,
  output logic [1:0]       sel_a,
  output logic [1:0]       sel_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  tag_t             r_ex_tag;
  tag_t             r_mem_tag;
  tag_t             r_wb_tag;
  tag_t             w_id_tag;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_a_ex_load_hit;
  logic             w_b_ex_load_hit;
  logic             w_stall;
  logic             w_bubble;

  if (AW > c_AW_MAX) begin : g_aw_check
    $error("fwd_operand_sel: AW exceeds tag rd width");
  end

  fwd_match_sel #(
    .DW (DW),
    .AW (AW)
  ) u_sel_a (
    .used        (id_rs_used),
    .addr        (id_rs),
    .ex_tag      (r_ex_tag),
    .mem_tag     (r_mem_tag),
    .wb_tag      (r_wb_tag),
    .rf_data     (rf_rs_data),
    .ex_data     (ex_result),
    .mem_data    (mem_result),
    .wb_data     (wb_result),
    .sel         (sel_a),
    .data        (op_a),
    .ex_load_hit (w_a_ex_load_hit)
  );

  fwd_match_sel #(
    .DW (DW),
    .AW (AW)
  ) u_sel_b (
    .used        (id_rt_used),
    .addr        (id_rt),
    .ex_tag      (r_ex_tag),
    .mem_tag     (r_mem_tag),
    .wb_tag      (r_wb_tag),
    .rf_data     (rf_rt_data),
    .ex_data     (ex_result),
    .mem_data    (mem_result),
    .wb_data     (wb_result),
    .sel         (sel_b),
    .data        (op_b),
    .ex_load_hit (w_b_ex_load_hit)
  );

  // A flushed instruction never consumes, so flush suppresses the stall.
  assign w_stall  = id_valid && !flush && (w_a_ex_load_hit || w_b_ex_load_hit);
  assign w_bubble = w_stall || flush || !id_valid;
  assign stall    = w_stall;
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    w_id_tag = c_TAG_EMPTY;
    if (!w_bubble) begin
      w_id_tag.v    = 1'b1;
      w_id_tag.rd   = c_AW_MAX'(id_rd);
      w_id_tag.wen  = id_wen;
      w_id_tag.load = id_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_tag    <= c_TAG_EMPTY;
      r_mem_tag   <= c_TAG_EMPTY;
      r_wb_tag    <= c_TAG_EMPTY;
      r_stall_cnt <= '0;
    end else if (!ext_hold) begin
      r_wb_tag  <= r_mem_tag;
      r_mem_tag <= r_ex_tag;
      r_ex_tag  <= w_id_tag;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fwd_operand_sel.sv
`default_nettype none
// ============================================================================
// tb_fwd_operand_sel : directed vector table plus hazard/hold/reset sequences
// Revision : 1.0
// ============================================================================
module tb_fwd_operand_sel;

  localparam logic [31:0] c_RF_RS = 32'hA0A0_0001;
  localparam logic [31:0] c_RF_RT = 32'hB0B0_0002;
  localparam logic [31:0] c_EX_V  = 32'h0000_0011;
  localparam logic [31:0] c_MEM_V = 32'h0000_0022;
  localparam logic [31:0] c_WB_V  = 32'h0000_0033;
  localparam logic [31:0] c_LOAD  = 32'h0000_DEAD;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wen;
    logic       load;
  } prod_t;

  typedef struct {
    prod_t      wb;
    prod_t      mem;
    prod_t      ex;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic       valid;
    logic       flush;
    logic [1:0] ea;
    logic [1:0] eb;
    logic       est;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic        id_rs_used = 1'b0, id_rt_used = 1'b0, id_wen = 1'b0, id_load = 1'b0;
  logic [31:0] rf_rs_data = c_RF_RS, rf_rt_data = c_RF_RT;
  logic [31:0] ex_result = c_EX_V, mem_result = c_MEM_V, wb_result = c_WB_V;
  logic        flush = 1'b0, ext_hold = 1'b0;
  logic [31:0] op_a, op_b, op_a2, op_b2;
  logic [1:0]  sel_a, sel_b, sel_a2, sel_b2;
  logic        stall, stall2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_operand_sel dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wen(id_wen),
    .id_load(id_load), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .flush(flush), .ext_hold(ext_hold), .op_a(op_a), .op_b(op_b), .sel_a(sel_a),
    .sel_b(sel_b), .stall(stall), .stall_cnt(stall_cnt)
  );

  fwd_operand_sel #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wen(id_wen),
    .id_load(id_load), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .flush(flush), .ext_hold(ext_hold), .op_a(op_a2), .op_b(op_b2), .sel_a(sel_a2),
    .sel_b(sel_b2), .stall(stall2), .stall_cnt(stall_cnt2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic prod_t mkp(input logic v, input logic [4:0] rd, input logic wen, input logic load);
    prod_t p;
    p.v = v; p.rd = rd; p.wen = wen; p.load = load;
    return p;
  endfunction

  function automatic logic [31:0] exp_op(input logic [1:0] s, input logic [31:0] rf);
    case (s)
      2'b01:   return c_EX_V;
      2'b10:   return c_MEM_V;
      2'b11:   return c_WB_V;
      default: return rf;
    endcase
  endfunction

  // Issue one instruction from ID that reads nothing, then clock it into EX.
  task automatic push(input prod_t p);
    id_valid = p.v; id_rd = p.rd; id_wen = p.wen; id_load = p.load;
    id_rs_used = 1'b0; id_rt_used = 1'b0; flush = 1'b0; ext_hold = 1'b0;
    tick();
  endtask

  task automatic consumer_rt7();
    id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd7; id_rs_used = 1'b0; id_rt_used = 1'b1;
    id_rd = 5'd8; id_wen = 1'b1; id_load = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; id_valid = 1'b0; flush = 1'b0; ext_hold = 1'b0;
    id_rs_used = 1'b0; id_rt_used = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic vec_t mkv(input prod_t wb, input prod_t mem, input prod_t ex,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic rsu, input logic rtu, input logic valid,
                               input logic fl, input logic [1:0] ea, input logic [1:0] eb,
                               input logic est);
    vec_t v;
    v.wb = wb; v.mem = mem; v.ex = ex; v.rs = rs; v.rt = rt; v.rs_used = rsu;
    v.rt_used = rtu; v.valid = valid; v.flush = fl; v.ea = ea; v.eb = eb; v.est = est;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs[14];
    prod_t n, a5, l7;
    n  = mkp(0, 5'd0, 0, 0);
    a5 = mkp(1, 5'd5, 1, 0);
    l7 = mkp(1, 5'd7, 1, 1);
    vecs[0]  = mkv(n, n, n, 5'd3, 5'd4, 1, 1, 1, 0, 2'b00, 2'b00, 0);
    vecs[1]  = mkv(a5, a5, a5, 5'd5, 5'd4, 1, 1, 1, 0, 2'b01, 2'b00, 0);
    vecs[2]  = mkv(n, a5, n, 5'd5, 5'd4, 1, 1, 1, 0, 2'b10, 2'b00, 0);
    vecs[3]  = mkv(a5, n, n, 5'd5, 5'd4, 1, 1, 1, 0, 2'b11, 2'b00, 0);
    vecs[4]  = mkv(n, n, mkp(1, 5'd0, 1, 0), 5'd0, 5'd0, 1, 1, 1, 0, 2'b00, 2'b00, 0);
    vecs[5]  = mkv(n, n, a5, 5'd5, 5'd5, 0, 1, 1, 0, 2'b00, 2'b01, 0);
    vecs[6]  = mkv(n, mkp(1, 5'd7, 1, 0), l7, 5'd1, 5'd7, 1, 1, 1, 0, 2'b00, 2'b10, 1);
    vecs[7]  = mkv(n, n, l7, 5'd1, 5'd7, 1, 1, 1, 1, 2'b00, 2'b00, 0);
    vecs[8]  = mkv(n, n, l7, 5'd1, 5'd7, 1, 1, 0, 0, 2'b00, 2'b00, 0);
    vecs[9]  = mkv(n, n, mkp(1, 5'd5, 0, 0), 5'd5, 5'd4, 1, 1, 1, 0, 2'b00, 2'b00, 0);
    vecs[10] = mkv(mkp(1, 5'd6, 1, 0), n, a5, 5'd6, 5'd5, 1, 1, 1, 0, 2'b11, 2'b01, 0);
    vecs[11] = mkv(n, n, mkp(1, 5'd0, 1, 1), 5'd0, 5'd0, 1, 1, 1, 0, 2'b00, 2'b00, 0);
    vecs[12] = mkv(n, a5, l7, 5'd7, 5'd5, 1, 1, 1, 0, 2'b00, 2'b10, 1);
    vecs[13] = mkv(mkp(1, 5'd5, 1, 1), n, n, 5'd5, 5'd4, 1, 1, 1, 0, 2'b11, 2'b00, 0);

    // Reset state
    do_reset();
    id_valid = 1'b1; id_rs = 5'd3; id_rs_used = 1'b1; id_rt = 5'd4; id_rt_used = 1'b1;
    #1;
    check("reset sel_a", sel_a, 2'b00);
    check("reset op_a", op_a, c_RF_RS);
    check("reset sel_b", sel_b, 2'b00);
    check("reset op_b", op_b, c_RF_RT);
    check("reset stall", stall, 1'b0);
    check("reset stall_cnt", stall_cnt, 16'd0);

    // Table of producer pipelines and ID queries
    for (int i = 0; i < 14; i++) begin
      push(vecs[i].wb);
      push(vecs[i].mem);
      push(vecs[i].ex);
      id_valid = vecs[i].valid; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_rs_used = vecs[i].rs_used; id_rt_used = vecs[i].rt_used;
      flush = vecs[i].flush; id_rd = 5'd1; id_wen = 1'b0; id_load = 1'b0;
      #1;
      check($sformatf("vec%0d sel_a", i), sel_a, vecs[i].ea);
      check($sformatf("vec%0d sel_b", i), sel_b, vecs[i].eb);
      check($sformatf("vec%0d op_a", i), op_a, exp_op(vecs[i].ea, c_RF_RS));
      check($sformatf("vec%0d op_b", i), op_b, exp_op(vecs[i].eb, c_RF_RT));
      check($sformatf("vec%0d stall", i), stall, vecs[i].est);
    end

    // Load-use: one stall cycle, then forwarded from MEM
    do_reset();
    mem_result = c_LOAD;
    push(l7);
    consumer_rt7();
    #1;
    check("lu stall", stall, 1'b1);
    tick();
    check("lu stall after", stall, 1'b0);
    check("lu sel_b", sel_b, 2'b10);
    check("lu op_b", op_b, c_LOAD);
    check("lu stall_cnt", stall_cnt, 16'd1);
    tick();
    check("lu stall_cnt held", stall_cnt, 16'd1);

    // Flush together with a load-use: no stall, bubble enters EX
    do_reset();
    push(l7);
    consumer_rt7();
    id_rd = 5'd9; flush = 1'b1;
    #1;
    check("flush stall", stall, 1'b0);
    tick();
    flush = 1'b0; id_rs = 5'd9; id_rs_used = 1'b1;
    #1;
    check("flush ex bubble sel_a", sel_a, 2'b00);
    check("flush load in mem sel_b", sel_b, 2'b10);
    check("flush no stall", stall, 1'b0);
    check("flush stall_cnt", stall_cnt, 16'd0);

    // ext_hold freezes tags and counter while stall is still driven
    do_reset();
    push(l7);
    consumer_rt7();
    ext_hold = 1'b1;
    #1;
    check("hold stall", stall, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold%0d stall", k), stall, 1'b1);
      check($sformatf("hold%0d stall_cnt", k), stall_cnt, 16'd0);
      check($sformatf("hold%0d sel_b", k), sel_b, 2'b00);
    end
    ext_hold = 1'b0;
    tick();
    check("release stall_cnt", stall_cnt, 16'd1);
    check("release stall", stall, 1'b0);
    check("release sel_b", sel_b, 2'b10);

    // Saturation: five stall cycles into a 2-bit counter
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push(l7);
      consumer_rt7();
      tick();
    end
    check("sat cnt2", stall_cnt2, 2'd3);
    check("sat cnt16", stall_cnt, 16'd5);

    // Asynchronous reset mid-sequence clears tags without a clock edge
    mem_result = c_MEM_V;
    push(a5);
    push(mkp(1, 5'd6, 1, 0));
    id_valid = 1'b1; id_rs = 5'd5; id_rt = 5'd6; id_rs_used = 1'b1; id_rt_used = 1'b1;
    id_rd = 5'd1; id_wen = 1'b0; id_load = 1'b0;
    #1;
    check("pre-rst sel_a", sel_a, 2'b10);
    check("pre-rst sel_b", sel_b, 2'b01);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rst sel_a", sel_a, 2'b00);
    check("async rst sel_b", sel_b, 2'b00);
    check("async rst op_a", op_a, c_RF_RS);
    check("async rst stall_cnt", stall_cnt, 16'd0);
    check("async rst stall_cnt2", stall_cnt2, 2'd0);
    #1;
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
